// File: rtl/exe_rdy_gen_pkg.sv
// Shared constants, FSM state types and tag helper for the execution-side
// readiness generator.
package exe_pkg;

  localparam int unsigned PRG_SIG_WIDTH = 7;
  localparam int unsigned BRN_WIDTH     = 7;
  localparam int unsigned NUM_PORTS     = 4;

  localparam int unsigned FUN_MULT_BIT  = 0;
  localparam int unsigned FUN_ADD1_BIT  = 1;
  localparam int unsigned FUN_ADD2_BIT  = 2;
  localparam int unsigned FUN_ADDR_BIT  = 3;

  localparam int unsigned PORT_MUL      = 0;
  localparam int unsigned PORT_ALU1     = 1;
  localparam int unsigned PORT_ALU2     = 2;
  localparam int unsigned PORT_ADR      = 3;

  typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;
  typedef enum logic {ADR_IDLE, ADR_WAIT} adr_state_t;

  // A tag only wakes consumers when its valid bit is set.
  function automatic logic [PRG_SIG_WIDTH-1:0] wak_tag(input logic [PRG_SIG_WIDTH-1:0] pdst);
    return pdst[PRG_SIG_WIDTH-1] ? pdst : '0;
  endfunction

endpackage

// File: rtl/exe_rdy_gen_if.sv
// Issue-stage <-> execution readiness bundle: dispatches in, availability and
// wakeup tags out.
interface exe_rdy_gen_if;
  import exe_pkg::*;

  logic                            mul_iss_vld;
  logic                            alu1_iss_vld;
  logic                            alu2_iss_vld;
  logic                            adr_iss_vld;
  logic [PRG_SIG_WIDTH-1:0]        mul_pdst;
  logic [PRG_SIG_WIDTH-1:0]        alu1_pdst;
  logic [PRG_SIG_WIDTH-1:0]        alu2_pdst;
  logic [PRG_SIG_WIDTH-1:0]        adr_pdst;
  logic                            mem_rdy_frm_dc;
  logic [BRN_WIDTH-1:0]            fls_frm_rob;
  logic [NUM_PORTS-1:0]            fun_rdy_to_is;
  logic [NUM_PORTS*PRG_SIG_WIDTH-1:0] prg_rdy_to_is;
  logic                            iss_err;

  modport master (
    output mul_iss_vld, alu1_iss_vld, alu2_iss_vld, adr_iss_vld,
    output mul_pdst, alu1_pdst, alu2_pdst, adr_pdst,
    output mem_rdy_frm_dc, fls_frm_rob,
    input  fun_rdy_to_is, prg_rdy_to_is, iss_err
  );

  modport slave (
    input  mul_iss_vld, alu1_iss_vld, alu2_iss_vld, adr_iss_vld,
    input  mul_pdst, alu1_pdst, alu2_pdst, adr_pdst,
    input  mem_rdy_frm_dc, fls_frm_rob,
    output fun_rdy_to_is, prg_rdy_to_is, iss_err
  );

endinterface

// File: rtl/exe_rdy_gen_mul_trk.sv
// Non-pipelined multiplier tracker: countdown FSM that reports availability
// and broadcasts the latched destination when the count expires.
module mul_trk
  import exe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_fls,
  input  logic                     i_vld,
  input  logic [PRG_SIG_WIDTH-1:0] i_pdst,
  output logic                     o_rdy,
  output logic [PRG_SIG_WIDTH-1:0] o_wak
);

  localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

  mul_state_t               r_state;
  logic [2:0]               r_cnt;
  logic [PRG_SIG_WIDTH-1:0] r_pdst;
  logic                     r_rdy;
  logic [PRG_SIG_WIDTH-1:0] r_wak;

  // rdy/wak are registered from the next count so they line up with the
  // cycle in which the counter reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MUL_IDLE;
      r_cnt   <= '0;
      r_pdst  <= '0;
      r_rdy   <= 1'b0;
      r_wak   <= '0;
    end else if (i_fls) begin
      r_state <= MUL_IDLE;
      r_cnt   <= '0;
      r_rdy   <= 1'b1;
      r_wak   <= '0;
    end else if (i_vld && r_rdy) begin
      r_state <= MUL_BUSY;
      r_cnt   <= CNT_LOAD;
      r_pdst  <= i_pdst;
      r_rdy   <= 1'b0;
      r_wak   <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          r_rdy <= 1'b1;
          r_wak <= '0;
        end
        MUL_BUSY: begin
          if (r_cnt == 3'd0) begin
            r_state <= MUL_IDLE;
            r_rdy   <= 1'b1;
            r_wak   <= '0;
          end else if (r_cnt == 3'd1) begin
            r_cnt <= 3'd0;
            r_rdy <= 1'b1;
            r_wak <= wak_tag(r_pdst);
          end else begin
            r_cnt <= r_cnt - 3'd1;
            r_rdy <= 1'b0;
            r_wak <= '0;
          end
        end
        default: begin
          r_state <= MUL_IDLE;
          r_rdy   <= 1'b1;
          r_wak   <= '0;
        end
      endcase
    end
  end

  assign o_rdy = r_rdy;
  assign o_wak = r_wak;

endmodule

// File: rtl/exe_rdy_gen.sv
// Execution-side readiness generator: per-unit availability, wakeup tag
// broadcast, flush squash and sticky illegal-dispatch flag.
module exe_rdy_gen
  import exe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  exe_rdy_gen_if.slave bus
);

  logic                     w_fls;
  logic                     w_unused_fls;
  logic                     w_mul_rdy;
  logic [PRG_SIG_WIDTH-1:0] w_mul_wak;
  logic [NUM_PORTS-1:0]     w_fun;
  logic [NUM_PORTS-1:0]     w_vld;

  logic                     r_alu_rdy;
  logic [PRG_SIG_WIDTH-1:0] r_alu1_wak;
  logic [PRG_SIG_WIDTH-1:0] r_alu2_wak;
  adr_state_t               r_adr_state;
  logic [PRG_SIG_WIDTH-1:0] r_adr_pdst;
  logic                     r_adr_rdy;
  logic [PRG_SIG_WIDTH-1:0] r_adr_wak;
  logic                     r_err;

  assign w_fls        = bus.fls_frm_rob[BRN_WIDTH-1];
  assign w_unused_fls = ^bus.fls_frm_rob[BRN_WIDTH-2:0];

  mul_trk #(.MUL_LAT(MUL_LAT)) u_mul_trk (
    .clk    (clk),
    .rst    (rst),
    .i_fls  (w_fls),
    .i_vld  (bus.mul_iss_vld),
    .i_pdst (bus.mul_pdst),
    .o_rdy  (w_mul_rdy),
    .o_wak  (w_mul_wak)
  );

  always_comb begin
    w_fun               = '0;
    w_fun[FUN_MULT_BIT] = w_mul_rdy;
    w_fun[FUN_ADD1_BIT] = r_alu_rdy;
    w_fun[FUN_ADD2_BIT] = r_alu_rdy;
    w_fun[FUN_ADDR_BIT] = r_adr_rdy;
    w_vld               = '0;
    w_vld[FUN_MULT_BIT] = bus.mul_iss_vld;
    w_vld[FUN_ADD1_BIT] = bus.alu1_iss_vld;
    w_vld[FUN_ADD2_BIT] = bus.alu2_iss_vld;
    w_vld[FUN_ADDR_BIT] = bus.adr_iss_vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_rdy  <= 1'b0;
      r_alu1_wak <= '0;
      r_alu2_wak <= '0;
      r_err      <= 1'b0;
    end else begin
      r_alu_rdy  <= 1'b1;
      r_alu1_wak <= (!w_fls && bus.alu1_iss_vld && r_alu_rdy) ? wak_tag(bus.alu1_pdst) : '0;
      r_alu2_wak <= (!w_fls && bus.alu2_iss_vld && r_alu_rdy) ? wak_tag(bus.alu2_pdst) : '0;
      r_err      <= r_err | (|(w_vld & ~w_fun));
    end
  end

  // Stores finish on dispatch; only loads park the unit until data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr_state <= ADR_IDLE;
      r_adr_pdst  <= '0;
      r_adr_rdy   <= 1'b0;
      r_adr_wak   <= '0;
    end else if (w_fls) begin
      r_adr_state <= ADR_IDLE;
      r_adr_rdy   <= 1'b1;
      r_adr_wak   <= '0;
    end else begin
      case (r_adr_state)
        ADR_IDLE: begin
          r_adr_wak <= '0;
          if (bus.adr_iss_vld && r_adr_rdy && bus.adr_pdst[PRG_SIG_WIDTH-1]) begin
            r_adr_state <= ADR_WAIT;
            r_adr_pdst  <= bus.adr_pdst;
            r_adr_rdy   <= 1'b0;
          end else begin
            r_adr_rdy   <= 1'b1;
          end
        end
        ADR_WAIT: begin
          if (bus.mem_rdy_frm_dc) begin
            r_adr_state <= ADR_IDLE;
            r_adr_rdy   <= 1'b1;
            r_adr_wak   <= r_adr_pdst;
          end else begin
            r_adr_wak   <= '0;
          end
        end
        default: begin
          r_adr_state <= ADR_IDLE;
          r_adr_rdy   <= 1'b1;
          r_adr_wak   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.prg_rdy_to_is = '0;
    bus.prg_rdy_to_is[PORT_MUL*PRG_SIG_WIDTH  +: PRG_SIG_WIDTH] = w_mul_wak;
    bus.prg_rdy_to_is[PORT_ALU1*PRG_SIG_WIDTH +: PRG_SIG_WIDTH] = r_alu1_wak;
    bus.prg_rdy_to_is[PORT_ALU2*PRG_SIG_WIDTH +: PRG_SIG_WIDTH] = r_alu2_wak;
    bus.prg_rdy_to_is[PORT_ADR*PRG_SIG_WIDTH  +: PRG_SIG_WIDTH] = r_adr_wak;
  end

  assign bus.fun_rdy_to_is = w_fun;
  assign bus.iss_err       = r_err;

endmodule

// File: tb/tb_exe_rdy_gen.sv
// Scoreboard bench for exe_rdy_gen: directed scenarios then random traffic,
// checked cycle by cycle against a completion-time reference model.
module tb_exe_rdy_gen;

  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exe_rdy_gen_if bus ();

  exe_rdy_gen #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] fun;
    logic [27:0] prg;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // stimulus for the upcoming cycle
  logic       s_rst, s_fls, s_mem;
  logic       s_mul_v, s_alu1_v, s_alu2_v, s_adr_v;
  logic [6:0] s_mul_p, s_alu1_p, s_alu2_p, s_adr_p;
  logic [5:0] s_fls_idx;

  // reference model state: ops are tracked by their completion cycle
  logic       m_mul_act;
  int         m_mul_done;
  logic [6:0] m_mul_tag;
  logic       m_adr_wait;
  logic [6:0] m_adr_tag;
  logic       m_err;
  logic [3:0] m_fun;

  task automatic model_step(input int k);
    exp_t       e;
    logic [3:0] vld;
    e.cyc = k + 1;
    e.prg = '0;
    vld   = {s_adr_v, s_alu2_v, s_alu1_v, s_mul_v};
    if (s_rst) begin
      m_mul_act  = 1'b0;
      m_adr_wait = 1'b0;
      m_err      = 1'b0;
      m_fun      = 4'b0000;
    end else begin
      if ((vld & ~m_fun) != 4'b0000) m_err = 1'b1;
      if (s_fls) begin
        m_mul_act  = 1'b0;
        m_adr_wait = 1'b0;
      end else begin
        if (m_mul_act && m_mul_done == k + 1 && m_mul_tag[6]) e.prg[6:0] = m_mul_tag;
        if (s_mul_v && m_fun[0]) begin
          m_mul_act  = 1'b1;
          m_mul_done = k + MUL_LAT;
          m_mul_tag  = s_mul_p;
        end
        if (s_alu1_v && m_fun[1] && s_alu1_p[6]) e.prg[13:7]  = s_alu1_p;
        if (s_alu2_v && m_fun[2] && s_alu2_p[6]) e.prg[20:14] = s_alu2_p;
        if (m_adr_wait) begin
          if (s_mem) begin
            e.prg[27:21] = m_adr_tag;
            m_adr_wait   = 1'b0;
          end
        end else if (s_adr_v && m_fun[3] && s_adr_p[6]) begin
          m_adr_wait = 1'b1;
          m_adr_tag  = s_adr_p;
        end
      end
      m_fun[0] = !m_mul_act || (k + 1 >= m_mul_done);
      m_fun[1] = 1'b1;
      m_fun[2] = 1'b1;
      m_fun[3] = !m_adr_wait;
    end
    e.fun = m_fun;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    s_rst = 0; s_fls = 0; s_mem = 0; s_fls_idx = '0;
    s_mul_v = 0; s_alu1_v = 0; s_alu2_v = 0; s_adr_v = 0;
    s_mul_p = '0; s_alu1_p = '0; s_alu2_p = '0; s_adr_p = '0;
  endtask

  task automatic apply();
    @(posedge clk);
    #1;
    rst                = s_rst;
    bus.mul_iss_vld    = s_mul_v;
    bus.alu1_iss_vld   = s_alu1_v;
    bus.alu2_iss_vld   = s_alu2_v;
    bus.adr_iss_vld    = s_adr_v;
    bus.mul_pdst       = s_mul_p;
    bus.alu1_pdst      = s_alu1_p;
    bus.alu2_pdst      = s_alu2_p;
    bus.adr_pdst       = s_adr_p;
    bus.mem_rdy_frm_dc = s_mem;
    bus.fls_frm_rob    = {s_fls, s_fls_idx};
    model_step(cyc);
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) apply();
  endtask

  // monitor: every cycle the DUT presents a full output set
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL stale cyc=%0d expectation for cycle %0d never checked", cyc, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        total++;
        if (bus.fun_rdy_to_is !== e.fun) begin
          bad++;
          $display("FAIL fun_rdy cyc=%0d got=%b exp=%b", cyc, bus.fun_rdy_to_is, e.fun);
        end
        total++;
        if (bus.prg_rdy_to_is !== e.prg) begin
          bad++;
          $display("FAIL prg_rdy cyc=%0d got=%h exp=%h", cyc, bus.prg_rdy_to_is, e.prg);
        end
        total++;
        if (bus.iss_err !== e.err) begin
          bad++;
          $display("FAIL iss_err cyc=%0d got=%b exp=%b", cyc, bus.iss_err, e.err);
        end
      end
    end
  end

  initial begin
    clr();
    s_rst = 1;
    m_mul_act = 0; m_mul_done = 0; m_mul_tag = '0;
    m_adr_wait = 0; m_adr_tag = '0; m_err = 0; m_fun = '0;
    rst = 1'b1;
    bus.mul_iss_vld = 0; bus.alu1_iss_vld = 0; bus.alu2_iss_vld = 0; bus.adr_iss_vld = 0;
    bus.mul_pdst = '0; bus.alu1_pdst = '0; bus.alu2_pdst = '0; bus.adr_pdst = '0;
    bus.mem_rdy_frm_dc = 0; bus.fls_frm_rob = '0;

    apply(); apply();
    idle(3);

    // ALU wakeup and no-destination op
    s_alu1_v = 1; s_alu1_p = 7'h45; apply();
    idle(1);
    s_alu2_v = 1; s_alu2_p = 7'h05; apply();
    idle(2);

    // multiplier with back-to-back dispatch in the broadcast cycle
    s_mul_v = 1; s_mul_p = 7'h6A; apply();
    idle(3);
    s_mul_v = 1; s_mul_p = 7'h41; apply();
    idle(5);

    // load waits for cache data
    s_adr_v = 1; s_adr_p = 7'h52; apply();
    idle(4);
    s_mem = 1; apply();
    idle(2);

    // store: no broadcast, unit stays available
    s_adr_v = 1; s_adr_p = 7'h10; apply();
    s_mem = 0; s_adr_v = 0; apply();
    s_mem = 1; apply();
    idle(2);

    // flush squashes an in-flight multiply
    s_mul_v = 1; s_mul_p = 7'h6A; apply();
    idle(1);
    s_fls = 1; s_fls_idx = 6'h15; apply();
    idle(6);

    // illegal dispatch while busy; original op still completes
    s_mul_v = 1; s_mul_p = 7'h73; apply();
    idle(1);
    s_mul_v = 1; s_mul_p = 7'h44; apply();
    idle(5);

    // reset pulse clears the sticky error
    s_rst = 1; apply();
    idle(3);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      clr();
      s_rst     = ($urandom_range(0, 199) == 0);
      s_fls     = ($urandom_range(0, 39) == 0);
      s_fls_idx = 6'($urandom);
      s_mem     = ($urandom_range(0, 3) == 0);
      s_mul_v   = ($urandom_range(0, 2) == 0);
      s_alu1_v  = ($urandom_range(0, 2) == 0);
      s_alu2_v  = ($urandom_range(0, 2) == 0);
      s_adr_v   = ($urandom_range(0, 2) == 0);
      s_mul_p   = 7'($urandom);
      s_alu1_p  = 7'($urandom);
      s_alu2_p  = 7'($urandom);
      s_adr_p   = 7'($urandom);
      apply();
    end
    idle(MUL_LAT + 2);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
